// File: rtl/jtkunio_arb_pkg.sv
// Shared types and constants for the ROM slot arbiter.
// The FSM state encoding, the default bank address width and the burst length.
package jtkunio_arb_pkg;

   typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

   localparam int BA_AW    = 22;
   localparam int DW_BURST = 2;

endpackage

// File: rtl/jtkunio_arb_slot.sv
// One client slot: a 32-bit cache entry plus tag/valid, and a zero-latency hit comparator.
// The fill lands one cycle after fill is asserted; the hit path is purely combinational and has no backpressure.
module jtkunio_arb_slot
   import jtkunio_arb_pkg::*;
#(
   parameter int AW = BA_AW
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          clr,
   input  logic          fill,
   input  logic [AW-2:0] fill_tag,
   input  logic [31:0]   fill_data,
   output logic [31:0]   data,
   output logic          ok
);

   logic          valid;
   logic [AW-2:0] tag;
   logic          unused_lsb;

   // The fill is gated against clr upstream, so clr only needs to win over the valid set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         tag   <= '0;
         data  <= '0;
      end else begin
         if (clr)
            valid <= 1'b0;
         else if (fill)
            valid <= 1'b1;
         if (fill) begin
            tag  <= fill_tag;
            data <= fill_data;
         end
      end
   end

   assign ok         = cs & valid & (tag == addr[AW-1:1]);
   assign unused_lsb = addr[0];

endmodule

// File: rtl/jtkunio_rom_arb.sv
// Shares one SDRAM bank among SLOTS ROM clients; hits return with zero latency, and misses are fetched round-robin as 2x16-bit bursts.
// A miss takes one cycle to grant, then waits for ba_ack and the burst; define JTKUNIO_ARB_PRIO0_EN to give slot 0 priority and to gate data on ba_dst.
module jtkunio_rom_arb
   import jtkunio_arb_pkg::*;
#(
   parameter int SLOTS         = 4,
   parameter int AW            = BA_AW,
   parameter int CLRTAG_ON_DWN = 1
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                downloading,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS*32-1:0] slot_data,
   output logic [SLOTS-1:0]    slot_ok,
   output logic [AW-1:0]       ba_addr,
   output logic                ba_rd,
   input  logic                ba_ack,
   input  logic                ba_dst,
   input  logic                ba_dok,
   input  logic                ba_rdy,
   input  logic [15:0]         data_read,
   output logic                busy
);

   localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int CW = $clog2(DW_BURST);

   state_t         state, state_nx;
   logic [GW-1:0]  grant, last_grant, pick;
   logic [AW-1:0]  pick_addr;
   logic [AW-2:0]  lat_tag;
   logic [31:0]    burst_buf, buf_nx;
   logic [CW-1:0]  cnt;
   logic [SLOTS-1:0] miss;
   logic           clr, dok_eff, grant_en, rdy_en, fill_en;
   logic [1:0]     unused_bits;

   assign clr   = (CLRTAG_ON_DWN != 0) && downloading;
   assign miss  = slot_cs & ~slot_ok;
   assign ba_rd = (state == REQ);
   assign busy  = (state != IDLE);

   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      jtkunio_arb_slot #(.AW(AW)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .cs        (slot_cs[i]),
         .addr      (slot_addr[i*AW +: AW]),
         .clr       (clr),
         .fill      (fill_en && (grant == GW'(i))),
         .fill_tag  (lat_tag),
         .fill_data (buf_nx),
         .data      (slot_data[i*32 +: 32]),
         .ok        (slot_ok[i])
      );
   end

   // Scan downwards so the nearest miss after last_grant is the one left standing.
   always_comb begin
      logic [GW:0] sum;
      pick = '0;
      sum  = '0;
      for (int k = SLOTS; k >= 1; k--) begin
         sum = {1'b0, last_grant} + (GW+1)'(k);
         if (sum >= (GW+1)'(SLOTS))
            sum = sum - (GW+1)'(SLOTS);
         if (miss[sum[GW-1:0]])
            pick = sum[GW-1:0];
      end
`ifdef JTKUNIO_ARB_PRIO0_EN
      if (miss[0])
         pick = '0;
`endif
   end

   always_comb begin
      pick_addr = '0;
      for (int i = 0; i < SLOTS; i++)
         if (pick == GW'(i))
            pick_addr = slot_addr[i*AW +: AW];
   end

   always_comb begin
      state_nx = state;
      grant_en = 1'b0;
      rdy_en   = 1'b0;
      case (state)
         IDLE: if (!downloading && (|miss)) begin
            state_nx = REQ;
            grant_en = 1'b1;
         end
         REQ:  if (ba_ack) state_nx = DATA;
         DATA: if (ba_rdy) begin
            state_nx = IDLE;
            rdy_en   = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign fill_en = rdy_en & ~clr;

`ifdef JTKUNIO_ARB_PRIO0_EN
   logic dst_seen;
   assign dok_eff = (state == DATA) && ba_dok && dst_seen;
`else
   assign dok_eff = (state == DATA) && ba_dok;
`endif

   // Same-cycle view of the buffer so a word arriving with ba_rdy still makes the fill.
   always_comb begin
      buf_nx = burst_buf;
      if (dok_eff) begin
         if (cnt == '0)
            buf_nx[15:0]  = data_read;
         else
            buf_nx[31:16] = data_read;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant      <= '0;
         last_grant <= '0;
         lat_tag    <= '0;
         ba_addr    <= '0;
         burst_buf  <= '0;
         cnt        <= '0;
      end else begin
         if (grant_en) begin
            grant   <= pick;
            lat_tag <= pick_addr[AW-1:1];
            ba_addr <= {pick_addr[AW-1:1], 1'b0};
         end
         if (state == REQ && ba_ack)
            cnt <= '0;
         if (dok_eff) begin
            cnt       <= cnt + 1'b1;
            burst_buf <= buf_nx;
         end
`ifdef JTKUNIO_ARB_PRIO0_EN
         if (rdy_en && grant != '0)
            last_grant <= grant;
`else
         if (rdy_en)
            last_grant <= grant;
`endif
      end
   end

`ifdef JTKUNIO_ARB_PRIO0_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dst_seen <= 1'b0;
      else if (state == REQ)
         dst_seen <= 1'b0;
      else if (state == DATA && ba_dst)
         dst_seen <= 1'b1;
   end
`endif

   assign unused_bits = {ba_dst, pick_addr[0]};

endmodule

// File: tb/tb_jtkunio_rom_arb.sv
// Directed bench for jtkunio_rom_arb: a bank model driven from one initial block, with a queue of expected bank addresses.
module tb_jtkunio_rom_arb;

   localparam int SLOTS = 4;
   localparam int AW    = 22;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                downloading;
   logic [SLOTS-1:0]    slot_cs;
   logic [SLOTS*AW-1:0] slot_addr;
   logic [SLOTS*32-1:0] slot_data;
   logic [SLOTS-1:0]    slot_ok;
   logic [AW-1:0]       ba_addr;
   logic                ba_rd;
   logic                ba_ack, ba_dst, ba_dok, ba_rdy;
   logic [15:0]         data_read;
   logic                busy;

   int checks = 0;
   int errors = 0;
   logic [AW-1:0] exp_q[$];

   jtkunio_rom_arb #(.SLOTS(SLOTS), .AW(AW), .CLRTAG_ON_DWN(1)) dut (
      .clk(clk), .rst_n(rst_n), .downloading(downloading),
      .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_data(slot_data), .slot_ok(slot_ok),
      .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_dst(ba_dst),
      .ba_dok(ba_dok), .ba_rdy(ba_rdy), .data_read(data_read), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fdat(input logic [AW-1:0] a);
      return {a[15:0] + 16'h1234, a[15:0] ^ 16'h5A5A};
   endfunction

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      slot_addr[i*AW +: AW] = a;
   endtask

   task automatic wait_rd();
      bit seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge clk);
         #1;
         if (ba_rd) seen = 1'b1;
      end
      check("rd_seen", {127'd0, seen}, 128'd1);
   endtask

   task automatic pop_check_addr();
      logic [AW-1:0] e;
      e = '1;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("ba_addr", ba_addr, e);
   endtask

   task automatic no_rd(input int n, input string tag);
      int hits = 0;
      repeat (n) begin
         @(negedge clk);
         #1;
         if (ba_rd) hits++;
      end
      check(tag, hits, 0);
   endtask

   // Bank model: ack three cycles after the request, ba_dst, then two words with ba_rdy on the second.
   task automatic serve(input logic [15:0] w0, input logic [15:0] w1, input bit mid_chg, input bit mid_dwn);
      wait_rd();
      pop_check_addr();
      repeat (3) @(negedge clk);
      ba_ack = 1'b1;
      @(negedge clk);
      ba_ack = 1'b0;
      ba_dst = 1'b1;
      if (mid_chg) set_addr(1, 22'h000300);
      if (mid_dwn) downloading = 1'b1;
      @(negedge clk);
      ba_dst = 1'b0;
      ba_dok = 1'b1;
      data_read = w0;
      @(negedge clk);
      data_read = w1;
      ba_rdy = 1'b1;
      @(negedge clk);
      ba_dok = 1'b0;
      ba_rdy = 1'b0;
      data_read = '0;
      #1;
   endtask

   task automatic serve_f(input bit mid_chg, input bit mid_dwn);
      logic [31:0] d;
      d = (exp_q.size() > 0) ? fdat(exp_q[0]) : 32'h0;
      serve(d[15:0], d[31:16], mid_chg, mid_dwn);
   endtask

   initial begin
      rst_n = 1'b0; downloading = 1'b0; slot_cs = '0; slot_addr = '0;
      ba_ack = 1'b0; ba_dst = 1'b0; ba_dok = 1'b0; ba_rdy = 1'b0; data_read = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ba_rd", ba_rd, 0);
      check("rst_busy", busy, 0);
      check("rst_ok", slot_ok, 0);
      check("rst_ba_addr", ba_addr, 0);
      check("rst_data", slot_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single miss then hit on the odd word of the same pair.
      set_addr(0, 22'h000124);
      slot_cs = 4'b0001;
      exp_q.push_back(22'h000124);
      #1 check("miss_ok0", slot_ok[0], 0);
      serve(16'hBEEF, 16'hCAFE, 1'b0, 1'b0);
      check("fill_data0", slot_data[31:0], 32'hCAFEBEEF);
      check("hit_ok0", slot_ok[0], 1);
      set_addr(0, 22'h000125);
      #1 check("hit_odd_ok0", slot_ok[0], 1);
      no_rd(8, "hit_no_rd");

      // Slot 3 alone, leaving last_grant at 3.
      set_addr(3, 22'h000400);
      slot_cs = 4'b1001;
      exp_q.push_back(22'h000400);
      serve_f(1'b0, 1'b0);
      check("ok3", slot_ok[3], 1);

      // Two rounds of simultaneous misses: both start at slot 0.
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < SLOTS; i++) begin
            set_addr(i, AW'(16 * (i + 1 + 4 * r)));
            exp_q.push_back(AW'(16 * (i + 1 + 4 * r)));
         end
         slot_cs = 4'b1111;
         for (int i = 0; i < SLOTS; i++) serve_f(1'b0, 1'b0);
         check("rr_ok", slot_ok, 4'hF);
         for (int i = 0; i < SLOTS; i++)
            check("rr_data", slot_data[i*32 +: 32], fdat(AW'(16 * (i + 1 + 4 * r))));
      end

      // Address change while the burst is in DATA.
      slot_cs = 4'b0010;
      set_addr(1, 22'h000200);
      exp_q.push_back(22'h000200);
      exp_q.push_back(22'h000300);
      serve_f(1'b1, 1'b0);
      check("chg_ok1", slot_ok[1], 0);
      check("chg_data1", slot_data[63:32], fdat(22'h000200));
      serve_f(1'b0, 1'b0);
      check("chg_ok1_after", slot_ok[1], 1);

      // Download rises mid-burst: burst ends, caches cleared, no grants.
      set_addr(0, 22'h000050);
      set_addr(2, 22'h000600);
      slot_cs = 4'b0101;
      #1 check("dwn_pre_ok", slot_ok, 4'b0001);
      exp_q.push_back(22'h000600);
      serve_f(1'b0, 1'b1);
      check("dwn_busy", busy, 0);
      check("dwn_ok", slot_ok, 0);
      no_rd(10, "dwn_no_rd");
      check("dwn_ok_hold", slot_ok, 0);
      downloading = 1'b0;
      exp_q.push_back(22'h000050);
      exp_q.push_back(22'h000600);
      serve_f(1'b0, 1'b0);
      serve_f(1'b0, 1'b0);
      check("dwn_resume_ok", slot_ok, 4'b0101);

      // Asynchronous reset in the middle of a burst.
      slot_cs = 4'b0010;
      set_addr(1, 22'h000700);
      exp_q.push_back(22'h000700);
      wait_rd();
      pop_check_addr();
      @(negedge clk);
      ba_ack = 1'b1;
      @(negedge clk);
      ba_ack = 1'b0;
      @(negedge clk);
      ba_dok = 1'b1;
      data_read = 16'h1111;
      #2 rst_n = 1'b0;
      #1;
      check("arst_ba_rd", ba_rd, 0);
      check("arst_busy", busy, 0);
      check("arst_ok", slot_ok, 0);
      check("arst_ba_addr", ba_addr, 0);
      ba_dok = 1'b0;
      data_read = '0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(22'h000700);
      serve_f(1'b0, 1'b0);
      check("arst_refill_ok", slot_ok[1], 1);
      check("arst_refill_data", slot_data[63:32], fdat(22'h000700));

      check("sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
